// File: rtl/stream_demux_pkg.sv
// Shared types and sizes for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output holding register; refills on the same edge it drains.
module stream_demux_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         slot_ready
);
    assign slot_ready = !valid || ready;

    // Load wins over drain so a ready consumer sees no bubble between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demux; per-beat in_sel picks the destination slot.
// Optional per-channel transfer counters under STREAM_DEMUX_1_4_COUNT_EN.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  sel_t             in_sel,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [W-1:0]     out_data [N_OUT]
`ifdef STREAM_DEMUX_1_4_COUNT_EN
    ,
    output cnt_t             out_count [N_OUT]
`endif
);
    logic [N_OUT-1:0] slot_rdy;
    logic [N_OUT-1:0] load;

    // Only the addressed slot gates the input, so a stalled lane never blocks the others.
    assign in_ready = slot_rdy[in_sel];

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign load[i] = in_valid && in_ready && (in_sel == sel_t'(i));

        stream_demux_slot #(.W(W)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[i]),
            .d          (in_data),
            .ready      (out_ready[i]),
            .valid      (out_valid[i]),
            .q          (out_data[i]),
            .slot_ready (slot_rdy[i])
        );

`ifdef STREAM_DEMUX_1_4_COUNT_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                out_count[i] <= '0;
            else if (out_valid[i] && out_ready[i])
                out_count[i] <= out_count[i] + cnt_t'(1);
        end
`endif
    end
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed-vector bench for stream_demux_1_4 (counter checks when STREAM_DEMUX_1_4_COUNT_EN is set).
module tb_stream_demux_1_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data [4];
`ifdef STREAM_DEMUX_1_4_COUNT_EN
    logic [7:0]   out_count [4];
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    stream_demux_1_4 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_1_4_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
        #12;
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid: got %b want 0000", out_valid);
        end
        rst_n = 1'b1;
        tick();
        // fill slots 1 and 2, nothing drains
        drive(1'b1, 2'd1, 4'h7); tick();
        drive(1'b1, 2'd2, 4'h8); tick();
        drive(1'b0, 2'd0, 4'h0);
        vectors++;
        if (out_valid !== 4'b0110) begin
            errors++; $display("FAIL prefill_valid: got %b want 0110", out_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL async_reset_valid: got %b want 0000", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_data[i] !== 4'h0) begin
                errors++; $display("FAIL async_reset_data%0d: got %h want 0", i, out_data[i]);
            end
        end
        #2 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 4'h0);
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready sel%0d: got %b want 1", s, in_ready);
            end
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
    endtask

    task automatic test_routing();
        logic [W-1:0] dv [4];
        dv[0] = 4'ha; dv[1] = 4'hb; dv[2] = 4'hc; dv[3] = 4'hd;
        out_ready = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), dv[s]);
            vectors++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL route_in_ready sel%0d: got %b want 1", s, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 4'(1 << s) || out_data[s] !== dv[s]) begin
                errors++;
                $display("FAIL route_lane%0d: got valid %b data %h want valid %b data %h",
                         s, out_valid, out_data[s], 4'(1 << s), dv[s]);
            end
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL route_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_stall_isolation();
        out_ready = 4'b1110;
        drive(1'b1, 2'd0, 4'h5); tick();
        drive(1'b1, 2'd0, 4'h6);
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready0: got %b want 0", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 4'b0001 || out_data[0] !== 4'h5) begin
            errors++; $display("FAIL stall_hold: got valid %b data %h want 0001 5", out_valid, out_data[0]);
        end
        // retarget while stalled: lane 3 is free
        drive(1'b1, 2'd3, 4'h7);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_in_ready3: got %b want 1", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 4'b1001 || out_data[3] !== 4'h7 || out_data[0] !== 4'h5) begin
            errors++;
            $display("FAIL stall_lane3: got valid %b d3 %h d0 %h want 1001 7 5", out_valid, out_data[3], out_data[0]);
        end
        drive(1'b0, 2'd0, 4'h0);
        out_ready = 4'b1111;
        tick();
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL stall_drain: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b0000;
        drive(1'b1, 2'd1, 4'h3); tick();
        out_ready = 4'b0010;
        drive(1'b1, 2'd1, 4'h9);
        vectors++;
        if (in_ready !== 1'b1 || out_data[1] !== 4'h3) begin
            errors++; $display("FAIL b2b_ready: got rdy %b d1 %h want 1 3", in_ready, out_data[1]);
        end
        tick();
        vectors++;
        if (out_valid !== 4'b0010 || out_data[1] !== 4'h9) begin
            errors++; $display("FAIL b2b_refill: got valid %b data %h want 0010 9", out_valid, out_data[1]);
        end
        drive(1'b1, 2'd1, 4'he); tick();
        vectors++;
        if (out_valid !== 4'b0010 || out_data[1] !== 4'he) begin
            errors++; $display("FAIL b2b_refill2: got valid %b data %h want 0010 e", out_valid, out_data[1]);
        end
        drive(1'b0, 2'd0, 4'h0); tick();
        vectors++;
        if (out_valid !== 4'b0000 || out_data[1] !== 4'he) begin
            errors++; $display("FAIL b2b_drain_hold: got valid %b data %h want 0000 e", out_valid, out_data[1]);
        end
    endtask

    task automatic test_all_full();
        out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 4'(s + 1));
            tick();
        end
        vectors++;
        if (out_valid !== 4'b1111) begin
            errors++; $display("FAIL full_valid: got %b want 1111", out_valid);
        end
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 4'hf);
            vectors++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL full_in_ready sel%0d: got %b want 0", s, in_ready);
            end
        end
        out_ready = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            drive(1'(s % 2), 2'(s), 4'hf);
            vectors++;
            if (in_ready !== (s == 2)) begin
                errors++; $display("FAIL full_ready2 sel%0d: got %b want %b", s, in_ready, s == 2);
            end
        end
        drive(1'b0, 2'd0, 4'h0);
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (out_data[s] !== 4'(s + 1)) begin
                errors++; $display("FAIL full_data%0d: got %h want %h", s, out_data[s], 4'(s + 1));
            end
        end
        out_ready = 4'b1111;
        tick();
        vectors++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL full_drain: got %b want 0000", out_valid);
        end
    endtask

`ifdef STREAM_DEMUX_1_4_COUNT_EN
    task automatic test_count();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_count[i] !== 8'd0) begin
                errors++; $display("FAIL count_reset%0d: got %0d want 0", i, out_count[i]);
            end
        end
        tick();
        out_ready = 4'b1111;
        for (int n = 0; n < 257; n++) begin
            drive(1'b1, 2'd3, 4'(n));
            tick();
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        vectors++;
        if (out_count[3] !== 8'd1) begin
            errors++; $display("FAIL count_wrap3: got %0d want 1", out_count[3]);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_count[i] !== 8'd0) begin
                errors++; $display("FAIL count_other%0d: got %0d want 0", i, out_count[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_stall_isolation();
        test_back_to_back();
        test_all_full();
`ifdef STREAM_DEMUX_1_4_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
Registered 1-to-4 stream demultiplexer; the distributing counterpart of the 4:1 selection mux.
- Routes one valid/ready input stream to one of four output channels, chosen by a per-beat select.
- Each output has a one-entry holding register, so a stalled channel blocks only beats addressed to it.
- Sits between a single producer and four independent consumers in the datapath exercises.

Parameters:
W, 4, data width in bits of in_data and each out_data lane

Ports:
clk        input   1      clock; all state updates on rising edge
rst_n      input   1      asynchronous, active-low reset
in_valid   input   1      input beat present
in_ready   output  1      block accepts input beat this cycle
in_data    input   W      input payload
in_sel     input   2      destination channel of current beat (0..3)
out_valid  output  4      bit i: channel i holds a beat
out_ready  input   4      bit i: consumer i takes beat this cycle
out_data   output  4xW    lane i: payload of channel i (unpacked array [4], each W bits)

Behaviour:
- Reset (rst_n low, async assert, sync deassert): out_valid=0, every out_data lane=0, counters (if enabled)=0. Held beats are discarded. Inputs are ignored while rst_n is low.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer on channel i: out_valid[i] && out_ready[i].
- in_ready is combinational: !out_valid[in_sel] || out_ready[in_sel]. It depends only on the selected channel and never on the other three. in_ready must not depend on in_valid.
- Latency: an accepted beat appears on out_valid[in_sel]/out_data[in_sel] the next cycle. There is no combinational path from in_data to out_data.
- Per-channel slot i, evaluated each edge:
  - load = input transfer && in_sel==i.
  - drain = output transfer on i.
  - load: out_data[i] <= in_data; out_valid[i] <= 1. This applies whether or not drain is active, so the slot is refilled back to back.
  - drain without load: out_valid[i] <= 0; out_data[i] holds its last value.
  - neither: hold.
- Stability: while out_valid[i] && !out_ready[i], out_data[i] and out_valid[i] hold.
- Independence: at most one channel loads per cycle, but any number may drain in the same cycle.
- Throughput: 1 beat/cycle sustained when the selected consumer is always ready, including the same channel on consecutive cycles.
- in_sel and in_data need only be valid while in_valid=1. Changing in_sel while stalled (in_valid=1, in_ready=0) is allowed and re-evaluates in_ready.
- Boundaries:
  - All four slots full with no ready: in_ready=0 for every in_sel.
  - Full slot with ready asserted: in_ready=1 (pass-through refill).

Optional Feature:
STREAM_DEMUX_1_4_COUNT_EN
- Defined:
  - Adds output port out_count, 4x8 bits (unpacked array [4]).
  - Lane i increments by 1 on each output transfer on channel i.
  - 8-bit wrap from 255 to 0; reset value 0.
- Undefined: the port and the counters are absent. Datapath behaviour is identical in both cases.

Decomposition:
- Package stream_demux_pkg:
  - localparam N_OUT=4, SEL_W=2, CNT_W=8.
  - typedef logic [SEL_W-1:0] sel_t.
  - typedef logic [CNT_W-1:0] cnt_t.
- Sub-module stream_demux_slot (parameter W): one-entry register with ports clk, rst_n, load, d, ready, valid, q, and slot_ready = !valid || ready. The top instantiates it 4 times via generate and muxes in_ready from the four slot_ready bits by in_sel.

Test Plan:
- Reset: assert rst_n=0 mid-stream with slots 1 and 2 full -> out_valid=4'b0000 immediately (async), all out_data=0, in_ready=1 for any in_sel after release.
- Routing: out_ready=4'b1111; send data 'ha,'hb,'hc,'hd with in_sel 0,1,2,3 on consecutive cycles -> each appears one cycle later on its lane only (e.g. out_data[2]='hc, out_valid=4'b0100 that cycle); in_ready stays 1.
- Stall isolation: out_ready=4'b1110; send 'h5 sel 0, then 'h6 sel 0 -> 'h5 held on lane 0, in_ready=0 for sel 0; 'h7 sel 3 is accepted the same cycles and appears on lane 3.
- Back-to-back refill: lane 1 full with 'h3, out_ready[1]=1; send 'h9 sel 1 -> in_ready=1; next cycle out_valid[1]=1, out_data[1]='h9 with no bubble.
- All full: fill lanes 0..3 with out_ready=0 -> in_ready=0 for in_sel 0..3; raise out_ready[2] only -> in_ready=1 only when in_sel=2.
- COUNT_EN: drain 257 beats on channel 3 -> out_count[3]=1 (wrapped), other lanes unchanged.
